ch7301_i2c_config: RTL and testbench

CH7301_I2C_CONFIG -- requirements
Module: ch7301_i2c_config

---
 rtl/ch7301_i2c_config_if.sv | 7 +
 rtl/ch7301_i2c_config.sv | 142 ++++++++++++++
 tb/tb_ch7301_i2c_config.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/ch7301_i2c_config_if.sv
// ch7301_i2c_config_if: start/status handshake and open-drain I2C pad controls of the CH7301 configurator
interface ch7301_i2c_config_if;
  logic start, sda_i, scl_oe, sda_oe, busy, done, error;
  logic [3:0] reg_idx;
  modport master (input start, sda_i, output scl_oe, sda_oe, busy, done, error, reg_idx);
  modport slave (output start, sda_i, input scl_oe, sda_oe, busy, done, error, reg_idx);
endinterface

// File: rtl/ch7301_i2c_config.sv
// ch7301_i2c_config: writes a fixed 9-entry register table to the CH7301 over I2C, with per-entry NACK retry
module ch7301_i2c_config #(
  parameter int CLK_DIV = 250,
  parameter logic [6:0] DEV_ADDR = 7'h76,
  parameter int MAX_RETRY = 3
) (
  input logic clk,
  input logic rst_n,
  ch7301_i2c_config_if.master bus
);
  localparam int DW = $clog2(CLK_DIV + 1);
  localparam logic [DW-1:0] DIV_END = DW'(CLK_DIV - 1);
  localparam logic [7:0] RETRY_END = 8'(MAX_RETRY);
  typedef enum logic [2:0] {IDLE, START, BYTE, ACK, STOP, GAP, FINISH, FAIL} state_t;
  state_t state;
  logic [DW-1:0] div;
  logic [1:0] q, byte_cnt;
  logic [2:0] bit_cnt, nxt_bit;
  logic [7:0] retry, cur_byte, nxt_byte;
  logic nack, tick;
  function automatic logic [15:0] entry(input logic [3:0] i);
    case (i)
      4'd0: entry = 16'h1C04;
      4'd1: entry = 16'h1D45;
      4'd2: entry = 16'h1F80;
      4'd3: entry = 16'h2109;
      4'd4: entry = 16'h3308;
      4'd5: entry = 16'h3416;
      4'd6: entry = 16'h3660;
      4'd7: entry = 16'h4818;
      default: entry = 16'h49C0;
    endcase
  endfunction
  function automatic logic [7:0] tx_byte(input logic [3:0] i, input logic [1:0] b);
    logic [15:0] e;
    e = entry(i);
    tx_byte = b == 2'd0 ? {DEV_ADDR, 1'b0} : b == 2'd1 ? e[15:8] : e[7:0];
  endfunction
  assign tick = div == DIV_END;
  assign nxt_bit = bit_cnt + 3'd1;
  assign cur_byte = tx_byte(bus.reg_idx, byte_cnt);
  assign nxt_byte = tx_byte(bus.reg_idx, byte_cnt + 2'd1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      div <= '0;
      q <= '0;
      byte_cnt <= '0;
      bit_cnt <= '0;
      retry <= '0;
      nack <= 1'b0;
      bus.scl_oe <= 1'b0;
      bus.sda_oe <= 1'b0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.error <= 1'b0;
      bus.reg_idx <= '0;
    end else begin
      div <= tick || state == IDLE ? '0 : div + 1'b1;
      case (state)
        IDLE: if (bus.start) begin
          state <= START;
          bus.busy <= 1'b1;
          bus.done <= 1'b0;
          bus.error <= 1'b0;
          bus.reg_idx <= '0;
          retry <= '0;
          nack <= 1'b0;
          q <= '0;
          byte_cnt <= '0;
          bit_cnt <= '0;
        end
        START: if (tick) begin
          q <= q + 2'd1;
          if (q == 2'd0) bus.sda_oe <= 1'b1;
          if (q == 2'd1) bus.scl_oe <= 1'b1;
          if (q == 2'd2) begin
            state <= BYTE;
            q <= '0;
            bus.sda_oe <= ~cur_byte[7];
          end
        end
        BYTE: if (tick) begin
          q <= q + 2'd1;
          if (q == 2'd1) bus.scl_oe <= 1'b0;
          if (q == 2'd3) begin
            bus.scl_oe <= 1'b1;
            bit_cnt <= nxt_bit;
            state <= bit_cnt == 3'd7 ? ACK : BYTE;
            bus.sda_oe <= bit_cnt == 3'd7 ? 1'b0 : ~cur_byte[~nxt_bit];
          end
        end
        ACK: if (tick) begin
          q <= q + 2'd1;
          if (q == 2'd1) bus.scl_oe <= 1'b0;
          if (q == 2'd2) nack <= bus.sda_i;
          if (q == 2'd3) begin
            bus.scl_oe <= 1'b1;
            byte_cnt <= byte_cnt + 2'd1;
            state <= nack || byte_cnt == 2'd2 ? STOP : BYTE;
            bus.sda_oe <= nack || byte_cnt == 2'd2 ? 1'b1 : ~nxt_byte[7];
          end
        end
        STOP: if (tick) begin
          q <= q + 2'd1;
          if (q == 2'd1) bus.scl_oe <= 1'b0;
          if (q == 2'd2) begin
            bus.sda_oe <= 1'b0;
            state <= GAP;
            q <= '0;
          end
        end
        GAP: if (tick) begin
          q <= q + 2'd1;
          if (q == 2'd3) begin
            byte_cnt <= '0;
            bit_cnt <= '0;
            nack <= 1'b0;
            if (nack) begin
              retry <= retry + 8'd1;
              state <= retry == RETRY_END ? FAIL : START;
            end else if (bus.reg_idx == 4'd8) state <= FINISH;
            else begin
              bus.reg_idx <= bus.reg_idx + 4'd1;
              retry <= '0;
              state <= START;
            end
          end
        end
        FINISH: begin
          bus.done <= 1'b1;
          bus.busy <= 1'b0;
          state <= IDLE;
        end
        FAIL: begin
          bus.error <= 1'b1;
          bus.busy <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
endmodule

// File: tb/tb_ch7301_i2c_config.sv
// tb_ch7301_i2c_config: I2C slave model plus transaction-level reference for the CH7301 configurator
module tb_ch7301_i2c_config;
  localparam int CLK_DIV = 2;
  localparam int MAX_RETRY = 3;
  localparam logic [6:0] DEV = 7'h76;
  typedef struct {
    int e;
    int a;
    int nb;
    logic [23:0] bytes;
  } txn_t;
  logic clk = 1'b0, rst_n = 1'b0;
  logic scl_p = 1'b1, sda_p = 1'b1, pull = 1'b0, in_x = 1'b0, ackph = 1'b0, hi_ev = 1'b1, armed = 1'b0;
  logic [7:0] sh = '0;
  logic [15:0] tbl [9] = '{16'h1C04, 16'h1D45, 16'h1F80, 16'h2109, 16'h3308, 16'h3416, 16'h3660, 16'h4818, 16'h49C0};
  bit nack_tab [9][MAX_RETRY+1][3];
  int bits = 0, nb = 0, txn = 0, gap = 1000, hi_len = 0, n_chk = 0, n_fail = 0;
  int exp_done, exp_err, exp_idx;
  txn_t exp_q[$];
  logic [7:0] obs_q[$];
  always #4 clk = ~clk;
  ch7301_i2c_config_if bus();
  ch7301_i2c_config #(.CLK_DIV(CLK_DIV), .DEV_ADDR(DEV), .MAX_RETRY(MAX_RETRY)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.master));
  assign bus.sda_i = ~(bus.sda_oe | pull);
  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endfunction
  // Expected bus transactions and final status follow directly from the slave's NACK table
  task automatic build_model();
    txn_t t;
    int a, k;
    bit ok, nk;
    exp_q.delete();
    exp_done = 1;
    exp_err = 0;
    exp_idx = 8;
    for (int e = 0; e < 9; e++) begin
      a = 0;
      ok = 0;
      while (!ok && a <= MAX_RETRY) begin
        nk = 0;
        k = 0;
        while (!nk && k < 3) begin
          nk = nack_tab[e][a][k];
          k++;
        end
        t.e = e;
        t.a = a;
        t.nb = k;
        t.bytes = {DEV, 1'b0, tbl[e]};
        exp_q.push_back(t);
        ok = !nk;
        a++;
      end
      if (!ok) begin
        exp_done = 0;
        exp_err = 1;
        exp_idx = e;
        break;
      end
    end
  endtask
  task automatic clear_tab();
    foreach (nack_tab[i, j, k]) nack_tab[i][j][k] = 0;
  endtask
  always @(negedge clk) begin : mon
    logic scl, sda;
    scl = ~bus.scl_oe;
    sda = ~(bus.sda_oe | pull);
    if (!rst_n) begin
      in_x = 0;
      pull = 0;
      ackph = 0;
      bits = 0;
      nb = 0;
      gap = 1000;
      hi_ev = 1;
    end else begin
      if (!armed) chk("idle_bus", {bus.scl_oe, bus.sda_oe, bus.busy}, 0);
      if (bus.busy) chk("busy_flags", {bus.done, bus.error}, 0);
      if (!in_x && gap < 1000) gap++;
      if (scl && scl_p && sda_p && !sda) begin
        chk("start_gap", gap >= 4 * CLK_DIV, 1);
        chk("rep_start", in_x, 0);
        chk("txn_extra", txn < exp_q.size(), 1);
        in_x = 1;
        bits = 0;
        nb = 0;
        ackph = 0;
        hi_ev = 1;
      end else if (scl && scl_p && !sda_p && sda) begin
        hi_ev = 1;
        if (in_x) begin
          if (txn < exp_q.size()) chk("txn_len", nb, exp_q[txn].nb);
          txn++;
        end
        in_x = 0;
        gap = 0;
      end
      if (scl) begin
        if (!scl_p) begin
          hi_len = 0;
          hi_ev = 0;
          if (in_x && !ackph) begin
            sh = {sh[6:0], sda};
            bits++;
          end
        end
        hi_len++;
      end else if (scl_p) begin
        if (!hi_ev) chk("scl_high", hi_len, 2 * CLK_DIV);
        if (in_x && ackph) begin
          pull = 0;
          ackph = 0;
          bits = 0;
        end else if (in_x && bits == 8) begin
          obs_q.push_back(sh);
          if (txn < exp_q.size()) begin
            chk("byte", sh, exp_q[txn].bytes[8*(2-nb) +: 8]);
            chk("reg_idx", bus.reg_idx, exp_q[txn].e);
            pull = !nack_tab[exp_q[txn].e][exp_q[txn].a][nb];
          end else pull = 1;
          nb++;
          ackph = 1;
        end
      end
    end
    scl_p = scl;
    sda_p = sda;
  end
  task automatic start_seq(input string nm);
    build_model();
    txn = 0;
    obs_q.delete();
    @(posedge clk);
    #1 bus.start = 1;
    armed = 1;
    @(posedge clk);
    #1 bus.start = 0;
    chk({nm, "_start"}, {bus.busy, bus.done, bus.error}, 3'b100);
  endtask
  task automatic finish_seq(input string nm);
    int t;
    t = 0;
    while (bus.busy && t < 40000) begin
      @(negedge clk);
      t++;
    end
    chk({nm, "_timeout"}, t < 40000, 1);
    repeat (2) @(negedge clk);
    chk({nm, "_txns"}, txn, exp_q.size());
    chk({nm, "_status"}, {bus.busy, bus.done, bus.error}, {1'b0, exp_done[0], exp_err[0]});
    chk({nm, "_idx"}, bus.reg_idx, exp_idx);
    chk({nm, "_released"}, {bus.scl_oe, bus.sda_oe}, 0);
    armed = 0;
  endtask
  task automatic run(input string nm, input bit extra);
    start_seq(nm);
    if (extra) begin
      repeat ($urandom_range(50, 600)) @(posedge clk);
      if (bus.busy) begin
        #1 bus.start = 1;
        @(posedge clk);
        #1 bus.start = 0;
      end
    end
    finish_seq(nm);
  endtask
  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int t;
    bus.start = 0;
    clear_tab();
    repeat (3) @(negedge clk);
    chk("rst_state", {bus.scl_oe, bus.sda_oe, bus.busy, bus.done, bus.error, bus.reg_idx}, 0);
    rst_n = 1;
    repeat (20) @(negedge clk);
    run("all_ack", 0);
    chk("lit_nbytes", obs_q.size(), 27);
    chk("lit_b0", obs_q[0], 8'hEC);
    chk("lit_b1", obs_q[1], 8'h1C);
    chk("lit_b2", obs_q[2], 8'h04);
    chk("lit_blast", obs_q[26], 8'hC0);
    chk("lit_done", {bus.done, bus.error, bus.reg_idx}, {2'b10, 4'd8});
    run("busy_start", 1);
    chk("lit_busy_txns", txn, 9);
    nack_tab[3][0][1] = 1;
    run("retry3", 0);
    chk("lit_retry_txns", txn, 10);
    chk("lit_retry_done", {bus.done, bus.error}, 2'b10);
    clear_tab();
    for (int a = 0; a <= MAX_RETRY; a++) nack_tab[5][a][0] = 1;
    run("fail5", 0);
    chk("lit_fail_txns", txn, 9);
    chk("lit_fail_nbytes", obs_q.size(), 19);
    chk("lit_fail_stat", {bus.done, bus.error, bus.reg_idx}, {2'b01, 4'd5});
    clear_tab();
    start_seq("rst_mid");
    t = 0;
    while (!(txn == 2 && in_x && nb == 1 && bits >= 3) && t < 20000) begin
      @(negedge clk);
      t++;
    end
    chk("rst_reach", t < 20000, 1);
    #2 rst_n = 0;
    armed = 0;
    #1 chk("rst_async", {bus.scl_oe, bus.sda_oe, bus.busy, bus.done, bus.error, bus.reg_idx}, 0);
    repeat (3) @(negedge clk);
    rst_n = 1;
    repeat (300) @(negedge clk);
    run("after_rst", 0);
    chk("lit_after_rst", {bus.done, bus.reg_idx, txn[7:0]}, {1'b1, 4'd8, 8'd9});
    for (int r = 0; r < 5; r++) begin
      foreach (nack_tab[i, j, k]) nack_tab[i][j][k] = $urandom_range(0, 5) == 0;
      repeat ($urandom_range(1, 50)) @(negedge clk);
      run("rand", $urandom_range(0, 1) == 1);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
